mux_sel_arb: RTL and testbench
==============================

# mux_sel_arb

Two-requester round-robin arbiter that drives the select (`s`) and enable (`enb`) inputs of the 2:1 `mux` stage directly downstream. Each requester owns one mux data input: requester A owns `a` and requester B owns `b`. The block grants one requester at a time and enforces a maximum hold window so neither input can starve the other. All outputs are registered, so the mux sees glitch-free control.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other side is waiting; legal range 1..15.
- `CNT_W`, default 4: width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_a`  input  1  requester A wants mux input `a` routed to `o`.
- `req_b`  input  1  requester B wants mux input `b` routed to `o`.
- `gnt_a`  output  1  A currently granted.
- `gnt_b`  output  1  B currently granted.
- `s`  output  1  mux select: 0 routes `a`, 1 routes `b`.
- `enb`  output  1  mux enable; high exactly when a grant is active.

## Operation
- States: IDLE, GRANT_A, GRANT_B.
- Internal state: a hold counter `cnt` (CNT_W bits) and a last-granted pointer `last` (0 = A, 1 = B).
- Reset: state = IDLE, `gnt_a`=0, `gnt_b`=0, `s`=0, `enb`=0, `cnt`=0, `last`=B. With this reset value of `last`, A wins the first tie.

IDLE:
- Only `req_a` high -> GRANT_A.
- Only `req_b` high -> GRANT_B.
- Both high -> grant the side opposite `last`.
- Neither high -> stay in IDLE.

Entering any grant state:
- `cnt` = 1.
- `last` = the granted side.

GRANT_X (Y is the other side), evaluated every cycle in this priority order:
1. `req_X`=0 and `req_Y`=1 -> GRANT_Y (direct handover, no idle bubble).
2. `req_X`=0 and `req_Y`=0 -> IDLE.
3. `req_X`=1, `cnt`==MAX_HOLD, `req_Y`=1 -> GRANT_Y (forced rotation).
4. `req_X`=1, `cnt`==MAX_HOLD, `req_Y`=0 -> stay in GRANT_X with `cnt` = 1 (a new window starts).
5. Otherwise -> stay in GRANT_X with `cnt` = `cnt`+1.

Outputs, all registered:
- `gnt_a` = (state==GRANT_A).
- `gnt_b` = (state==GRANT_B).
- `enb` = `gnt_a` | `gnt_b`.
- `s` = 1 in GRANT_B and 0 in GRANT_A.
- In IDLE, `s` holds its last value so the mux select does not toggle needlessly.
- `gnt_a` and `gnt_b` are never high together.
- With MAX_HOLD=1 and both sides requesting, grants alternate every cycle.
- `rst` has priority over every transition. If asserted mid-grant, the next edge forces the reset values, discards the counter, and resets `last` to B.

## Timing
- Request-to-grant latency is 1 cycle: `req_X` sampled high at edge k (from IDLE) -> `gnt_X`, `enb`, `s` updated after edge k.
- Release latency is 1 cycle: `req_X` sampled low at edge k -> `gnt_X` low after edge k. Same edge: `gnt_Y` high if `req_Y` was high, otherwise `enb`=0.
- Forced rotation: with both sides requesting continuously, each grant lasts exactly MAX_HOLD cycles.
- `s` and `enb` change only on clock edges. Downstream `o` is valid in the cycle where `enb`=1.
- `rst` is sampled only at clock edges. Outputs reach reset values after the first edge with `rst`=1.

## Test plan
- Reset, MAX_HOLD=4: hold `rst`=1 for 2 cycles with `req_a`=`req_b`=1 -> all outputs 0. Release `rst` -> after next edge `gnt_a`=1, `s`=0, `enb`=1.
- Single requester: `req_a`=1 for 10 cycles, `req_b`=0 -> `gnt_a`=1 for 10 consecutive cycles with no gaps, `s`=0. Drop `req_a` -> `enb`=0 one edge later, `s` stays 0.
- Contention: both requests held for 16 cycles -> grant pattern A×4, B×4, A×4, B×4. `s` reads 0,0,0,0,1,1,1,1,…. `enb` stays 1 throughout.
- Early handover: `req_a`=1 for 2 cycles then 0, while `req_b`=1 throughout -> `gnt_a` for 2 cycles, then `gnt_b` on the very next cycle. `enb` never drops.
- Reset mid-grant: both requesting, assert `rst` on the 3rd cycle of a GRANT_B window -> next cycle all outputs 0. Release `rst` with both still requesting -> A granted first.
- Idle hold of `s`: grant B for 2 cycles, then drop both requests -> after the transition edge `enb`=0, `gnt_b`=0, `s` remains 1. Assertion check for the whole run: `gnt_a` and `gnt_b` are never high together.

Source files
------------

// File: rtl/mux_sel_arb.sv
// Two-requester round-robin arbiter driving the select/enable of a downstream 2:1 mux.
// A bounded hold window forces rotation when both sides keep requesting.
module mux_sel_arb #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic s,
  output logic enb
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_reg, last_next;
  logic             gnt_a_next, gnt_b_next, s_next, enb_next;

  // Requests seen from the point of view of the current owner (X) and the other side (Y).
  logic   req_own, req_other;
  state_t other_state;
  logic   other_side;

  always_comb begin
    req_own     = (state_reg == GRANT_B) ? req_b : req_a;
    req_other   = (state_reg == GRANT_B) ? req_a : req_b;
    other_state = (state_reg == GRANT_B) ? GRANT_A : GRANT_B;
    other_side  = (state_reg == GRANT_B) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      s         <= 1'b0;
      enb       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      gnt_a     <= gnt_a_next;
      gnt_b     <= gnt_b_next;
      s         <= s_next;
      enb       <= enb_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        // On a tie, last_reg==1 (B granted last) hands the grant to A.
        if (req_a && (!req_b || last_reg)) begin
          state_next = GRANT_A;
          cnt_next   = CNT_ONE;
          last_next  = 1'b0;
        end else if (req_b) begin
          state_next = GRANT_B;
          cnt_next   = CNT_ONE;
          last_next  = 1'b1;
        end else begin
          cnt_next   = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        if (!req_own) begin
          if (req_other) begin
            state_next = other_state;
            cnt_next   = CNT_ONE;
            last_next  = other_side;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (cnt_reg == HOLD_LIMIT) begin
          if (req_other) begin
            state_next = other_state;
            cnt_next   = CNT_ONE;
            last_next  = other_side;
          end else begin
            cnt_next   = CNT_ONE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered; select holds while idle.
  always_comb begin
    gnt_a_next = (state_next == GRANT_A);
    gnt_b_next = (state_next == GRANT_B);
    enb_next   = gnt_a_next | gnt_b_next;
    if (state_next == GRANT_B)
      s_next = 1'b1;
    else if (state_next == GRANT_A)
      s_next = 1'b0;
    else
      s_next = s;
  end

endmodule

// File: tb/tb_mux_sel_arb.sv
// Table-driven bench for mux_sel_arb (MAX_HOLD=4): each vector's expected outputs
// go to a scoreboard queue when driven and are popped after the sampling edge.
module tb_mux_sel_arb;

  logic clk = 1'b0;
  logic rst, req_a, req_b;
  logic gnt_a, gnt_b, s, enb;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_done = 1'b0;

  typedef struct {
    logic rst;
    logic ra;
    logic rb;
    logic ga;
    logic gb;
    logic es;
    logic ee;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  mux_sel_arb #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .s     (s),
    .enb   (enb)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic a, input logic b,
                     input logic ga, input logic gb, input logic es, input logic ee,
                     input int reps);
    vec_t v;
    v.rst = r; v.ra = a; v.rb = b; v.ga = ga; v.gb = gb; v.es = es; v.ee = ee;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  // Mutual exclusion of grants, checked every cycle once reset has been applied.
  always @(posedge clk) begin
    #1;
    if (!run_done && n_checks > 0) begin
      n_checks++;
      if (gnt_a && gnt_b) begin
        n_fail++;
        $display("FAIL grant_mutex actual=%b%b required=not both", gnt_a, gnt_b);
      end
    end
  end

  initial begin
    vec_t e;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;

    // Reset held with both requesting, then release: A wins the first tie.
    add(1, 1, 1, 0, 0, 0, 0, 2);
    // Contention: A x4, B x4, A x4, B x4.
    add(0, 1, 1, 1, 0, 0, 1, 4);
    add(0, 1, 1, 0, 1, 1, 1, 4);
    add(0, 1, 1, 1, 0, 0, 1, 4);
    add(0, 1, 1, 0, 1, 1, 1, 4);
    // Drop both: idle, select holds at 1.
    add(0, 0, 0, 0, 0, 1, 0, 1);
    // Single requester for 10 cycles, window restarts without a gap.
    add(0, 1, 0, 1, 0, 0, 1, 10);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Early handover: A for 2 cycles, then B on the next cycle.
    add(0, 1, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1, 1, 1, 1);
    add(0, 1, 1, 0, 1, 1, 1, 2);
    // Reset on the 3rd cycle of the B window, release with both requesting.
    add(1, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 1, 1);
    // Grant B for 2 cycles, drop both: select stays 1 while idle.
    add(0, 0, 1, 0, 1, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1, 0, 2);
    // Tie from idle after A was last granted goes to B; then handover back to A.
    add(0, 1, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 1, 1, 1);
    add(0, 1, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 1, 0, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
      end else begin
        e = sb.pop_front();
        chk("gnt_a", i, gnt_a, e.ga);
        chk("gnt_b", i, gnt_b, e.gb);
        chk("s",     i, s,     e.es);
        chk("enb",   i, enb,   e.ee);
        $display("vec %0d rst=%b req=%b%b -> gnt=%b%b s=%b enb=%b", i,
                 vecs[i].rst, vecs[i].ra, vecs[i].rb, gnt_a, gnt_b, s, enb);
      end
    end

    run_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
